// File: rtl/i2s_tx.sv
// i2s_tx: I2S stereo serializer with one-pair buffer; define I2S_TX_HOLD_LAST_EN to repeat the last pair on underrun
module i2s_tx #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sample_l_i,
  input  logic [WIDTH-1:0] sample_r_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             sclk_o,
  output logic             lrclk_o,
  output logic             sdata_o,
  output logic             frame_start_o,
  output logic             underrun_o
);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST  = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SB    = CW'(SLOT_BITS);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d, pos, idx;
  logic             sclk_q, sclk_d, lr_q, lr_d, sd_q, sd_d, fs_q, fs_d, ur_q, ur_d, full_q, full_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d, hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] word, shw;
  logic             tick, fall, load, accept;
  always_comb begin
    tick     = div_q == DLAST;
    fall     = tick && sclk_q;
    load     = fall && cnt_q == LAST;
    accept   = valid_i && !full_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    sclk_d   = tick ? !sclk_q : sclk_q;
    cnt_d    = fall ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    // position 0 of each slot carries the last bit of the slot before it (one-bit I2S delay)
    word     = (cnt_d != '0 && cnt_d <= SB) ? sh_l_q : sh_r_q;
    pos      = cnt_d >= SB ? cnt_d - SB : cnt_d;
    idx      = (pos == '0 ? SB : pos) - 1'b1;
    shw      = word << idx;
    sd_d     = fall ? shw[WIDTH-1] : sd_q;
    lr_d     = fall ? cnt_d >= SB : lr_q;
    fs_d     = load;
    ur_d     = load && !full_q;
    sh_l_d   = load ? (full_q ? hold_l_q : (HOLD ? sh_l_q : '0)) : sh_l_q;
    sh_r_d   = load ? (full_q ? hold_r_q : (HOLD ? sh_r_q : '0)) : sh_r_q;
    hold_l_d = accept ? sample_l_i : hold_l_q;
    hold_r_d = accept ? sample_r_i : hold_r_q;
    full_d   = accept || (full_q && !load);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= '0;
      cnt_q    <= LAST;
      sclk_q   <= 1'b0;
      lr_q     <= 1'b1;
      sd_q     <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      full_q   <= 1'b0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
      lr_q     <= lr_d;
      sd_q     <= sd_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      full_q   <= full_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end
  assign ready_o       = !full_q;
  assign sclk_o        = sclk_q;
  assign lrclk_o       = lr_q;
  assign sdata_o       = sd_q;
  assign frame_start_o = fs_q;
  assign underrun_o    = ur_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed frame checks for i2s_tx at default parameters (WIDTH 24, SLOT 32, CLK_DIV 8)
module tb_i2s_tx;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] sample_l_i = '0;
  logic [23:0] sample_r_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, sclk_o, lrclk_o, sdata_o, frame_start_o, underrun_o;
  int          tests = 0;
  int          fails = 0;
  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] el;
    logic [31:0] er;
  } vec_t;
  vec_t v[4];
  i2s_tx dut (
    .clk_i(clk), .rst_i(rst_i), .sample_l_i(sample_l_i), .sample_r_i(sample_r_i),
    .valid_i(valid_i), .ready_o(ready_o), .sclk_o(sclk_o), .lrclk_o(lrclk_o),
    .sdata_o(sdata_o), .frame_start_o(frame_start_o), .underrun_o(underrun_o)
  );
  always #5 clk = !clk;
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic capture(input bit at_start, output logic [31:0] ls, output logic [30:0] rs,
                         output logic b0, output logic ur, output logic lr_ok);
    bit seen = at_start;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = frame_start_o;
    end
    check("frame_start_seen", {63'd0, seen}, 64'd1);
    ur    = underrun_o;
    b0    = sdata_o;
    lr_ok = lrclk_o == 1'b0;
    for (int n = 1; n < 64; n++) begin
      repeat (16) @(negedge clk);
      if (n <= 32) ls[32-n] = sdata_o;
      else rs[63-n] = sdata_o;
      lr_ok = lr_ok && (lrclk_o == (n >= 32));
    end
  endtask
  task automatic push(input logic [23:0] l, input logic [23:0] r, input bit keep, output bit at_fs);
    bit got = 0;
    sample_l_i = l;
    sample_r_i = r;
    valid_i    = 1'b1;
    at_fs      = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      got   = ready_o;
      at_fs = frame_start_o;
      @(negedge clk);
    end
    check("push_accepted", {63'd0, got}, 64'd1);
    if (!keep) valid_i = 1'b0;
  endtask
  task automatic check_frame(input string nm, input logic [31:0] ls, input logic [30:0] rs,
                             input logic b0, input logic ur, input logic lr_ok,
                             input logic [31:0] el, input logic [31:0] er, input logic eur);
    check({nm, "_left"}, {32'd0, ls}, {32'd0, el});
    check({nm, "_right"}, {33'd0, rs}, {33'd0, er[31:1]});
    check({nm, "_bit0"}, {63'd0, b0}, 64'd0);
    check({nm, "_underrun"}, {63'd0, ur}, {63'd0, eur});
    check({nm, "_lrclk"}, {63'd0, lr_ok}, 64'd1);
  endtask
  task automatic release_and_count(input string nm);
    int n = 0;
    int first_hi = 0;
    bit seen = 0;
    rst_i = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      n++;
      if (sclk_o && first_hi == 0) first_hi = n;
      seen = frame_start_o;
    end
    check({nm, "_first_sclk_rise"}, 64'(first_hi), 64'd8);
    check({nm, "_first_frame_cycle"}, 64'(n), 64'd16);
    check({nm, "_first_underrun"}, {63'd0, underrun_o}, 64'd1);
  endtask
  task automatic check_reset(input string nm);
    check({nm, "_sclk"}, {63'd0, sclk_o}, 64'd0);
    check({nm, "_lrclk"}, {63'd0, lrclk_o}, 64'd1);
    check({nm, "_sdata"}, {63'd0, sdata_o}, 64'd0);
    check({nm, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({nm, "_fs"}, {63'd0, frame_start_o}, 64'd0);
    check({nm, "_ur"}, {63'd0, underrun_o}, 64'd0);
  endtask
  initial begin
    logic [31:0] ls, hl, hr;
    logic [30:0] rs;
    logic        b0, ur, lr_ok;
    bit          afs;
    v[0] = '{24'h800001, 24'h7FFFFF, 32'h80000100, 32'h7FFFFF00};
    v[1] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFF00};
    v[2] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
    v[3] = '{24'h123456, 24'h000001, 32'h12345600, 32'h00000100};
    repeat (3) @(negedge clk);
    check_reset("reset");
    release_and_count("start");
    fork
      capture(1'b1, ls, rs, b0, ur, lr_ok);
      push(v[0].l, v[0].r, 1'b0, afs);
    join
    check_frame("idle_frame", ls, rs, b0, ur, lr_ok, 32'd0, 32'd0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) begin
        fork
          capture(1'b0, ls, rs, b0, ur, lr_ok);
          push(v[i].l, v[i].r, 1'b0, afs);
        join
      end else capture(1'b0, ls, rs, b0, ur, lr_ok);
      check_frame($sformatf("vec%0d", i - 1), ls, rs, b0, ur, lr_ok, v[i-1].el, v[i-1].er, 1'b0);
    end
`ifdef I2S_TX_HOLD_LAST_EN
    hl = 32'h12345600;
    hr = 32'h00000100;
`else
    hl = 32'd0;
    hr = 32'd0;
`endif
    capture(1'b0, ls, rs, b0, ur, lr_ok);
    check_frame("starve", ls, rs, b0, ur, lr_ok, hl, hr, 1'b1);
    fork
      begin
        push(24'h111111, 24'h222222, 1'b1, afs);
        check("b2b_ready_drop", {63'd0, ready_o}, 64'd0);
        push(24'h333333, 24'h444444, 1'b1, afs);
        check("b2b_accept_at_fs", {63'd0, afs}, 64'd1);
        push(24'h555555, 24'h666666, 1'b0, afs);
        check("b2b_accept_at_fs2", {63'd0, afs}, 64'd1);
      end
      begin
        capture(1'b0, ls, rs, b0, ur, lr_ok);
        check_frame("b2b_a", ls, rs, b0, ur, lr_ok, 32'h11111100, 32'h22222200, 1'b0);
        capture(1'b0, ls, rs, b0, ur, lr_ok);
        check_frame("b2b_b", ls, rs, b0, ur, lr_ok, 32'h33333300, 32'h44444400, 1'b0);
        capture(1'b0, ls, rs, b0, ur, lr_ok);
        check_frame("b2b_c", ls, rs, b0, ur, lr_ok, 32'h55555500, 32'h66666600, 1'b0);
      end
    join
    push(24'hABCDEF, 24'hFEDCBA, 1'b0, afs);
    push(24'h0F0F0F, 24'hF0F0F0, 1'b0, afs);
    repeat (160) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    release_and_count("after_reset");
    capture(1'b1, ls, rs, b0, ur, lr_ok);
    check_frame("post_reset", ls, rs, b0, ur, lr_ok, 32'd0, 32'd0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
